octree_mem_arbiter: RTL

Round-robin arbiter that shares one read port of the octree node memory (octant ROM) between N_CORES ray processor cores. Each core presents a valid/ready read request; the arbiter grants at most one request per cycle, drives the memory read port, and routes the returned node word back to the issuing core with a one-hot response strobe. It sits between the RayProcessor instances and the octant ROM, so core count can grow without adding ROM ports.

---
 rtl/octree_mem_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/octree_mem_arbiter.sv
// octree_mem_arbiter: round-robin arbiter sharing one octant ROM read port between N_CORES ray cores
//   clk, reset_n          : rising-edge clock, asynchronous active-low reset
//   en                    : arbitration enable (in-flight reads still complete when low)
//   req_valid/req_addr    : per-core read requests, core i address at [i*ADDR_W +: ADDR_W]
//   req_ready             : one-hot combinational grant
//   resp_valid/resp_data  : one-hot response strobe and returned node word
//   mem_ren/mem_addr/mem_dout : ROM read port
//   busy                  : any request pending or any read in flight
module octree_mem_arbiter #(
    parameter int N_CORES     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic [N_CORES-1:0]          req_valid,
    input  logic [N_CORES*ADDR_W-1:0]   req_addr,
    output logic [N_CORES-1:0]          req_ready,
    output logic [N_CORES-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        mem_ren,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_dout,
    output logic                        busy
);
    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [PW-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [MEM_LATENCY-1:0]          tag_v_q, tag_v_d;
    logic [MEM_LATENCY-1:0][PW-1:0]  tag_id_q, tag_id_d;
    logic                            gnt_found;
    logic [PW-1:0]                   gnt_idx;
    logic                            xfer;
    int                              scan_idx;

    // First requester at or after rr_ptr, wrapping around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_CORES; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % N_CORES;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(scan_idx);
            end
        end
    end

    // reset_n gating keeps every output at its reset value while reset is held
    always_comb begin
        xfer       = reset_n && en && gnt_found;
        req_ready  = xfer ? (N_CORES'(1) << gnt_idx) : '0;
        mem_ren    = xfer;
        mem_addr   = xfer ? req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;
        resp_valid = tag_v_q[MEM_LATENCY-1] ? (N_CORES'(1) << tag_id_q[MEM_LATENCY-1]) : '0;
        resp_data  = tag_v_q[MEM_LATENCY-1] ? mem_dout : '0;
        busy       = reset_n && ((|req_valid) || (|tag_v_q));
    end

    // Tag pipeline tracks which core owns each outstanding ROM read
    always_comb begin
        rr_ptr_d    = xfer ? PW'((int'(gnt_idx) + 1) % N_CORES) : rr_ptr_q;
        tag_v_d     = tag_v_q;
        tag_id_d    = tag_id_q;
        tag_v_d[0]  = xfer;
        tag_id_d[0] = gnt_idx;
        for (int k = 1; k < MEM_LATENCY; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
        end
    end
endmodule
